debug_ctrl_unit: RTL and testbench
==================================

// Module: debug_ctrl_unit
// PURPOSE
//  UART-driven debug controller between the UART rx/tx FIFOs and the MIPS datapath.
//  Decodes single-byte commands: step, run, halt, dump and datapath reset.
//  Gates the datapath through a clock-enable. Streams a latched datapath snapshot
//  of SNAP_BYTES bytes, LSB byte first, over the UART tx handshake.
//  Parametrised successor of the fixed-width step/continue debug unit.
// PARAMETERS
//  SNAP_BYTES  203    snapshot length in bytes; dp_bus width = SNAP_BYTES*8
//  CMD_STEP    8'h70  'p': one datapath cycle, then dump
//  CMD_RUN     8'h63  'c': free-run until dp_halt or CMD_HALT, then dump
//  CMD_HALT    8'h68  'h': stop free-run
//  CMD_DUMP    8'h64  'd': dump snapshot without advancing datapath
//  CMD_RESET   8'h72  'r': pulse dp_reset, clear halted status
// PORTS
//  clk        in   1              system clock, all logic on posedge
//  rst_n      in   1              asynchronous active-low reset
//  rx_rdy     in   1              rx_data valid this cycle (1-cycle strobe)
//  rx_data    in   8              received command byte
//  tx_done    in   1              UART finished accepting/sending current byte
//  dp_bus     in   SNAP_BYTES*8   live datapath state
//  dp_halt    in   1              datapath executed halt instruction
//  dp_clk_en  out  1              datapath advances one cycle per clk while high
//  dp_reset   out  1              synchronous datapath reset pulse (1 cycle)
//  tx_write   out  1              push tx_data to UART (1-cycle pulse)
//  tx_data    out  8              byte to transmit
//  busy       out  1              high in every state except IDLE and HALTED
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; dp_clk_en, dp_reset, tx_write, busy = 0;
//   tx_data=0; byte counter=0; snapshot register cleared. Aborts any dump/run mid-flight.
//  States: IDLE, STEP, RUN, LOAD, SEND, WAIT, HALTED.
//  IDLE: rx_rdy & CMD_STEP -> STEP; CMD_RUN -> RUN; CMD_DUMP -> LOAD;
//   CMD_RESET -> dp_reset=1 for 1 cycle, stay IDLE; other bytes ignored.
//  STEP: dp_clk_en=1 exactly one cycle -> LOAD.
//  RUN: dp_clk_en=1 every cycle. dp_halt=1 -> dp_clk_en=0 same cycle, -> LOAD,
//   halted flag set. rx_rdy & CMD_HALT -> LOAD. Both in same cycle: dp_halt wins.
//  LOAD: snapshot <= dp_bus (one cycle after last enabled edge); counter=0 -> SEND.
//  SEND: tx_data <= snapshot byte[counter]; tx_write=1 one cycle -> WAIT.
//  WAIT: tx_data held stable; tx_done sampled only here (never in SEND cycle).
//   On tx_done: counter+1; counter==SNAP_BYTES -> end of dump, else -> SEND.
//  End of dump: halted flag ? HALTED : IDLE.
//  HALTED: only CMD_DUMP (-> LOAD) and CMD_RESET (dp_reset pulse,
//   clear flag, -> IDLE) honoured; step/run ignored.
//  rx bytes arriving in STEP/RUN(non-halt)/LOAD/SEND/WAIT are dropped.
//  Counter width $clog2(SNAP_BYTES+1); no wrap; dump latency = 1+1+2*SNAP_BYTES+txwait.
//  dp_clk_en never high outside STEP/RUN; datapath state frozen during dump.
// CONFIGURATION
//  DBG_CHECKSUM_EN defined: after byte SNAP_BYTES-1, one extra byte sent =
//   XOR of all snapshot bytes (accumulated in SEND; cleared in LOAD);
//   frame length SNAP_BYTES+1.
//  Undefined: frame is exactly SNAP_BYTES bytes, no accumulator logic.
// TESTING
//  1 SNAP_BYTES=4, dp_bus=32'h44332211, rx 'd', tx_done 3 clk after each write
//    -> tx 11,22,33,44; dp_clk_en never high; ends IDLE.
//  2 rx 'p' -> dp_clk_en high exactly 1 cycle; 4-byte dump follows; busy high
//    until final tx_done.
//  3 rx 'c', dp_halt at cycle 10 -> dp_clk_en 0 from that cycle; dump; HALTED;
//    later 'p' ignored, 'r' -> dp_reset 1-cycle pulse, IDLE.
//  4 rx 'c', then 'h' and dp_halt in same cycle -> HALTED (halt wins); 'h' alone
//    -> IDLE after dump.
//  5 rst_n low during WAIT of byte 2 -> tx_write/dp_clk_en 0 immediately; after
//    release rx 'd' -> full dump from byte 0.
//  6 DBG_CHECKSUM_EN, dp_bus=32'h44332211 -> 5th byte 8'h44
//    (11^22^33^44); without macro only 4 bytes.

Source files
------------

// File: rtl/debug_ctrl_unit_if.sv
// Debug controller bundle: UART rx/tx handshake plus datapath control.
// slave = controller side, master = UART/datapath side.
interface debug_ctrl_unit_if #(
  parameter int SNAP_BYTES = 203
);
  logic                    rx_rdy;
  logic [7:0]              rx_data;
  logic                    tx_done;
  logic [SNAP_BYTES*8-1:0] dp_bus;
  logic                    dp_halt;
  logic                    dp_clk_en;
  logic                    dp_reset;
  logic                    tx_write;
  logic [7:0]              tx_data;
  logic                    busy;

  modport slave (
    input  rx_rdy,
    input  rx_data,
    input  tx_done,
    input  dp_bus,
    input  dp_halt,
    output dp_clk_en,
    output dp_reset,
    output tx_write,
    output tx_data,
    output busy
  );

  modport master (
    output rx_rdy,
    output rx_data,
    output tx_done,
    output dp_bus,
    output dp_halt,
    input  dp_clk_en,
    input  dp_reset,
    input  tx_write,
    input  tx_data,
    input  busy
  );
endinterface

// File: rtl/debug_ctrl_unit.sv
// UART-driven step/run/halt/dump debug controller for the MIPS datapath.
// Optional DBG_CHECKSUM_EN appends an XOR checksum byte to each dump.
module debug_ctrl_unit #(
  parameter int         SNAP_BYTES = 203,
  parameter logic [7:0] CMD_STEP   = 8'h70,
  parameter logic [7:0] CMD_RUN    = 8'h63,
  parameter logic [7:0] CMD_HALT   = 8'h68,
  parameter logic [7:0] CMD_DUMP   = 8'h64,
  parameter logic [7:0] CMD_RESET  = 8'h72
) (
  input logic              clk,
  input logic              rst_n,
  debug_ctrl_unit_if.slave dbg
);

`ifdef DBG_CHECKSUM_EN
  localparam int FRAME = SNAP_BYTES + 1;
`else
  localparam int FRAME = SNAP_BYTES;
`endif
  localparam int SW = SNAP_BYTES * 8;
  localparam int CW = $clog2(FRAME + 1);
  localparam logic [CW-1:0] LAST = CW'(FRAME - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_STEP,
    S_RUN,
    S_LOAD,
    S_SEND,
    S_WAIT,
    S_HALTED
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic            r_halted;
  logic [CW-1:0]   r_cnt;
  logic [SW-1:0]   r_snap;
  logic            r_tx_write;
  logic [7:0]      r_tx_data;
  logic            r_dp_reset;

  logic            w_rx_step;
  logic            w_rx_run;
  logic            w_rx_halt;
  logic            w_rx_dump;
  logic            w_rx_reset;
  logic [SW-1:0]   w_snap_sh;
  logic [7:0]      w_snap_byte;
  logic [7:0]      w_tx_byte;
  logic            w_clk_en;
  logic            w_busy;

  assign w_rx_step  = dbg.rx_rdy && (dbg.rx_data == CMD_STEP);
  assign w_rx_run   = dbg.rx_rdy && (dbg.rx_data == CMD_RUN);
  assign w_rx_halt  = dbg.rx_rdy && (dbg.rx_data == CMD_HALT);
  assign w_rx_dump  = dbg.rx_rdy && (dbg.rx_data == CMD_DUMP);
  assign w_rx_reset = dbg.rx_rdy && (dbg.rx_data == CMD_RESET);

  // LSB byte first: byte[n] sits at bits 8n+7:8n
  assign w_snap_sh   = r_snap >> {r_cnt, 3'b000};
  assign w_snap_byte = w_snap_sh[7:0];

`ifdef DBG_CHECKSUM_EN
  localparam logic [CW-1:0] CSUM_IDX = CW'(SNAP_BYTES);
  logic [7:0] r_csum;

  assign w_tx_byte = (r_cnt == CSUM_IDX) ? r_csum : w_snap_byte;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_csum <= 8'h00;
    end else if (r_state == S_LOAD) begin
      r_csum <= 8'h00;
    end else if (r_state == S_SEND && r_cnt != CSUM_IDX) begin
      r_csum <= r_csum ^ w_snap_byte;
    end
  end
`else
  assign w_tx_byte = w_snap_byte;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        unique case (1'b1)
          w_rx_step: w_next = S_STEP;
          w_rx_run:  w_next = S_RUN;
          w_rx_dump: w_next = S_LOAD;
          default:   w_next = S_IDLE;
        endcase
      end
      S_STEP: w_next = S_LOAD;
      S_RUN: begin
        if (dbg.dp_halt || w_rx_halt) begin
          w_next = S_LOAD;
        end
      end
      S_LOAD: w_next = S_SEND;
      S_SEND: w_next = S_WAIT;
      S_WAIT: begin
        if (dbg.tx_done) begin
          if (r_cnt == LAST) begin
            w_next = r_halted ? S_HALTED : S_IDLE;
          end else begin
            w_next = S_SEND;
          end
        end
      end
      S_HALTED: begin
        unique case (1'b1)
          w_rx_dump:  w_next = S_LOAD;
          w_rx_reset: w_next = S_IDLE;
          default:    w_next = S_HALTED;
        endcase
      end
      default: w_next = S_IDLE;
    endcase
  end

  // dp_halt drops the enable in the same cycle it is seen
  always_comb begin
    w_clk_en = 1'b0;
    w_busy   = 1'b1;
    unique case (r_state)
      S_IDLE:   w_busy   = 1'b0;
      S_HALTED: w_busy   = 1'b0;
      S_STEP:   w_clk_en = 1'b1;
      S_RUN:    w_clk_en = !dbg.dp_halt;
      default:  w_clk_en = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_halted   <= 1'b0;
      r_cnt      <= '0;
      r_snap     <= '0;
      r_tx_write <= 1'b0;
      r_tx_data  <= 8'h00;
      r_dp_reset <= 1'b0;
    end else begin
      r_tx_write <= 1'b0;
      r_dp_reset <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_rx_reset) begin
            r_dp_reset <= 1'b1;
            r_halted   <= 1'b0;
          end
        end
        S_RUN: begin
          if (dbg.dp_halt) begin
            r_halted <= 1'b1;
          end
        end
        S_LOAD: begin
          r_snap <= dbg.dp_bus;
          r_cnt  <= '0;
        end
        S_SEND: begin
          r_tx_data  <= w_tx_byte;
          r_tx_write <= 1'b1;
        end
        S_WAIT: begin
          if (dbg.tx_done) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_HALTED: begin
          if (w_rx_reset) begin
            r_dp_reset <= 1'b1;
            r_halted   <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign dbg.dp_clk_en = w_clk_en;
  assign dbg.busy      = w_busy;
  assign dbg.dp_reset  = r_dp_reset;
  assign dbg.tx_write  = r_tx_write;
  assign dbg.tx_data   = r_tx_data;

endmodule

// File: tb/tb_debug_ctrl_unit.sv
// Randomized scoreboard bench for debug_ctrl_unit with a 4-byte snapshot.
// Datapath is modelled as base + n*K where n counts enabled clock edges.
module tb_debug_ctrl_unit;
  localparam int SB = 4;
  localparam logic [7:0] C_STEP  = 8'h70;
  localparam logic [7:0] C_RUN   = 8'h63;
  localparam logic [7:0] C_HALT  = 8'h68;
  localparam logic [7:0] C_DUMP  = 8'h64;
  localparam logic [7:0] C_RESET = 8'h72;
  localparam logic [31:0] KSTEP  = 32'h01030507;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  debug_ctrl_unit_if #(.SNAP_BYTES(SB)) dbg ();

  debug_ctrl_unit #(.SNAP_BYTES(SB)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .dbg  (dbg)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int epoch = 0;
  int rst_pulses = 0;
  int m_cnt = 0;
  bit m_halted = 1'b0;
  logic [7:0] exp_q[$];

  logic [31:0] dp_base = 32'h44332211;
  int dp_cnt = 0;

  assign dbg.dp_bus = dp_base + 32'(dp_cnt) * KSTEP;

  always @(posedge clk) begin
    if (dbg.dp_reset) dp_cnt <= 0;
    else if (dbg.dp_clk_en) dp_cnt <= dp_cnt + 1;
  end

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (rst_n && dbg.tx_write) begin
      if (exp_q.size() == 0) begin
        check("tx_unexpected", {24'h0, dbg.tx_data}, 32'hffff_ffff);
      end else begin
        check("tx_byte", {24'h0, dbg.tx_data}, {24'h0, exp_q.pop_front()});
        check("busy_in_dump", {31'h0, dbg.busy}, 32'h1);
      end
    end
  end

  always @(negedge clk) begin
    if (dbg.dp_reset) rst_pulses++;
  end

  // UART model: acknowledge each write a few clocks later
  initial begin
    int ep;
    logic [7:0] d;
    dbg.tx_done = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && dbg.tx_write) begin
        ep = epoch;
        d = dbg.tx_data;
        repeat (2 + $urandom_range(0, 2)) @(negedge clk);
        if (ep == epoch) begin
          check("tx_hold", {24'h0, dbg.tx_data}, {24'h0, d});
          dbg.tx_done = 1'b1;
          @(negedge clk);
          dbg.tx_done = 1'b0;
        end
      end
    end
  end

  task automatic push_snap(input int n);
    logic [31:0] v;
    logic [7:0] x;
    v = dp_base + 32'(n) * KSTEP;
    x = 8'h00;
    for (int i = 0; i < SB; i++) begin
      exp_q.push_back(v[8*i +: 8]);
      x = x ^ v[8*i +: 8];
    end
`ifdef DBG_CHECKSUM_EN
    exp_q.push_back(x);
`endif
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    dbg.rx_rdy = 1'b1;
    dbg.rx_data = b;
    @(negedge clk);
    dbg.rx_rdy = 1'b0;
    dbg.rx_data = 8'($urandom);
  endtask

  task automatic wait_done(input string nm);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (!dbg.busy && exp_q.size() == 0) break;
    end
    check({nm, "_drain"}, exp_q.size(), 0);
    check({nm, "_busy"}, {31'h0, dbg.busy}, 32'h0);
    check({nm, "_dp_state"}, dp_cnt, m_cnt);
  endtask

  task automatic idle_check(input string nm);
    repeat (5) @(negedge clk);
    check({nm, "_busy"}, {31'h0, dbg.busy}, 32'h0);
    check({nm, "_dp_state"}, dp_cnt, m_cnt);
  endtask

  task automatic cmd_dump(input bit inject);
    push_snap(m_cnt);
    send(C_DUMP);
    if (inject) begin
      for (int i = 0; i < 50; i++) begin
        @(negedge clk);
        if (dbg.tx_write) break;
      end
      send(8'($urandom));
    end
    wait_done("dump");
  endtask

  task automatic cmd_step();
    if (m_halted) begin
      send(C_STEP);
      idle_check("step_ignored");
    end else begin
      m_cnt++;
      push_snap(m_cnt);
      send(C_STEP);
      wait_done("step");
    end
  endtask

  // mode 0: dp_halt pin, 1: 'h' command, 2: both in the same cycle
  task automatic cmd_run(input int k, input int mode);
    if (m_halted) begin
      send(C_RUN);
      idle_check("run_ignored");
    end else begin
      m_cnt += (mode == 1) ? k + 1 : k;
      if (mode != 1) m_halted = 1'b1;
      push_snap(m_cnt);
      send(C_RUN);
      repeat (k) @(negedge clk);
      if (mode != 1) dbg.dp_halt = 1'b1;
      if (mode != 0) begin
        dbg.rx_rdy = 1'b1;
        dbg.rx_data = C_HALT;
      end
      @(negedge clk);
      dbg.dp_halt = 1'b0;
      dbg.rx_rdy = 1'b0;
      wait_done("run");
    end
  endtask

  task automatic cmd_reset();
    int p0;
    p0 = rst_pulses;
    send(C_RESET);
    repeat (3) @(negedge clk);
    m_cnt = 0;
    m_halted = 1'b0;
    check("dp_reset_pulse", rst_pulses - p0, 1);
    check("reset_busy", {31'h0, dbg.busy}, 32'h0);
    check("reset_dp_state", dp_cnt, 0);
  endtask

  task automatic cmd_junk();
    logic [7:0] b;
    do b = 8'($urandom);
    while (b == C_STEP || b == C_RUN || b == C_HALT ||
           b == C_DUMP || b == C_RESET);
    send(b);
    idle_check("junk_ignored");
  endtask

  task automatic async_reset_test();
    int seen;
    seen = 0;
    push_snap(m_cnt);
    send(C_DUMP);
    for (int i = 0; i < 200 && seen < 2; i++) begin
      @(negedge clk);
      if (dbg.tx_write) seen++;
    end
    check("abort_reached_byte2", seen, 2);
    #2;
    epoch++;
    rst_n = 1'b0;
    #1;
    check("abort_tx_write", {31'h0, dbg.tx_write}, 32'h0);
    check("abort_clk_en", {31'h0, dbg.dp_clk_en}, 32'h0);
    check("abort_busy", {31'h0, dbg.busy}, 32'h0);
    check("abort_tx_data", {24'h0, dbg.tx_data}, 32'h0);
    exp_q.delete();
    m_halted = 1'b0;
    repeat (6) @(negedge clk);
    rst_n = 1'b1;
    cmd_dump(1'b0);
  endtask

  initial begin
    int op;
    dbg.rx_rdy = 1'b0;
    dbg.rx_data = 8'h00;
    dbg.dp_halt = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'h0, dbg.busy}, 32'h0);
    check("rst_tx_write", {31'h0, dbg.tx_write}, 32'h0);
    check("rst_clk_en", {31'h0, dbg.dp_clk_en}, 32'h0);
    check("rst_dp_reset", {31'h0, dbg.dp_reset}, 32'h0);
    check("rst_tx_data", {24'h0, dbg.tx_data}, 32'h0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    cmd_dump(1'b0);
    cmd_step();
    cmd_run(10, 0);
    cmd_step();
    cmd_run(3, 0);
    cmd_dump(1'b0);
    cmd_reset();
    cmd_run($urandom_range(0, 12), 2);
    cmd_reset();
    cmd_run($urandom_range(0, 12), 1);
    cmd_junk();
    async_reset_test();

    for (int it = 0; it < 30; it++) begin
      op = $urandom_range(0, 6);
      if (!dbg.busy) dp_base = $urandom;
      case (op)
        0: cmd_dump(1'($urandom));
        1: cmd_step();
        2: cmd_run($urandom_range(0, 12), 0);
        3: cmd_run($urandom_range(0, 12), 1);
        4: cmd_run($urandom_range(0, 12), 2);
        5: cmd_reset();
        default: cmd_junk();
      endcase
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
